mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_LIMIT, default 1024, byte-address bound of data memory (256 words); any access with addr >= ADDR_LIMIT is a fault.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces idle state and all registered outputs to 0.
REQ-004 req  input  1  access request from pipeline; sampled only in IDLE.
REQ-005 wr  input  1  1 = store, 0 = load; sampled with req.
REQ-006 size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal and is treated as a fault.
REQ-007 sign_ext  input  1  1 = sign-extend sub-word load (lb/lh), 0 = zero-extend (lbu/lhu).
REQ-008 addr  input  32  byte address; sampled with req.
REQ-009 wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]); sampled with req.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 fault  output  1  valid with done; 1 = misaligned, out-of-range or illegal size; no memory access performed.
REQ-013 rdata  output  32  load result, valid from done onward, held until next completed load.
REQ-014 mem_addr  output  32  word-aligned address to data memory (addr with [1:0] = 00).
REQ-015 mem_wdata  output  32  full word written to data memory.
REQ-016 mem_write  output  1  data-memory write enable.
REQ-017 mem_read  output  1  data-memory read enable.
REQ-018 mem_rdata  input  32  data-memory read word; combinational from mem_addr/mem_read.

Function
REQ-019 FSM states: IDLE, READ, WRITE, DONE; registered state, one-hot or binary at implementer's choice.
REQ-020 IDLE: req=1 captures wr, size, sign_ext, addr, wdata into internal registers; req=0 holds IDLE.
REQ-021 Fault check in IDLE on accept: halfword with addr[0]=1, word with addr[1:0]!=00, size=11, or addr >= ADDR_LIMIT -> DONE with fault=1; no mem_read/mem_write asserted.
REQ-022 Load: IDLE -> READ -> DONE; in READ, mem_read=1 and mem_rdata registered at end of cycle.
REQ-023 Word store: IDLE -> WRITE -> DONE.
REQ-024 Sub-word store: IDLE -> READ -> WRITE -> DONE; READ captures old word, WRITE drives merged word.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; req in DONE is ignored.
REQ-026 Latency from accepting edge to done: load 2 cycles, word store 2, sub-word store 3, fault 1.
REQ-027 Byte order big-endian: byte offset 0 = bits [31:24], offset 3 = [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
REQ-028 Store merge replaces only the addressed lane with wdata[7:0] or wdata[15:0]; other lanes keep the read value.
REQ-029 Load extraction selects the addressed lane, right-aligns it, extends per sign_ext; word loads pass through unchanged.
REQ-030 mem_write high only in WRITE, exactly one cycle; mem_addr and mem_wdata stable for the whole WRITE cycle.
REQ-031 mem_read high only in READ; mem_addr stable for the whole READ cycle; mem_read=0 and mem_write=0 in IDLE and DONE.
REQ-032 rdata updated only on a non-faulting load; stores and faults leave rdata unchanged.
REQ-033 req asserted while busy=1 is ignored, not queued; pipeline holds req until done.

Reset
REQ-034 On reset: state=IDLE; busy, done, fault, mem_read, mem_write = 0; rdata, mem_addr, mem_wdata = 0.
REQ-035 Reset mid-operation (READ or WRITE) aborts immediately and asynchronously: mem_write drops without waiting for clk, no done pulse.
REQ-036 First req accepted on the first rising edge after reset deasserts.

Verification
REQ-037 Memory word 0x40 = 0x11223344; load byte, addr 0x41, sign_ext=0 -> done 2 cycles after accept, rdata = 0x00000022, fault=0.
REQ-038 Memory word 0x40 = 0x80FF7F01; load halfword, addr 0x40, sign_ext=1 -> rdata = 0xFFFF80FF; addr 0x42, sign_ext=0 -> rdata = 0x00007F01.
REQ-039 Memory word 0x80 = 0xAABBCCDD; store byte 0x55 at addr 0x83 -> one mem_write cycle with mem_wdata = 0xAABBCC55, done 3 cycles after accept.
REQ-040 Store word 0xDEADBEEF at addr 0x10 -> mem_write for exactly one cycle, mem_addr = 0x10, no mem_read, done 2 cycles after accept.
REQ-041 Load word at addr 0x06, then halfword at 0x03, then byte at 0x400 -> each done 1 cycle after accept with fault=1, mem_read/mem_write never asserted, rdata unchanged.
REQ-042 Reset asserted during WRITE of a sub-word store -> mem_write falls without a clock edge, busy=0, no done; next request completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a pipeline and a word-wide data memory.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req, wr, size,      access request, 1=store, 00/01/10 = byte/half/word,
//   sign_ext, addr,     sign-extend sub-word loads, byte address,
//   wdata               right-aligned store data (all sampled in IDLE with req)
//   busy, done, fault   not idle, one-cycle completion pulse, access rejected
//   rdata               last completed load result
//   mem_addr, mem_wdata word-aligned memory address, full write word
//   mem_write, mem_read memory enables
//   mem_rdata           memory read word (combinational from mem_addr)
module mem_access_unit #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_n;
    logic        wr_q, sext_q, fault_q, bad;
    logic [1:0]  size_q;
    logic [31:0] addr_q, ld_val, mask, merged;
    logic [15:0] wdata_q, lane;
    logic [4:0]  sh;

    assign bad = size == 2'b11 || (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00) || addr >= ADDR_LIMIT;

    // Big-endian lanes: byte offset 0 lives in [31:24], so the right shift
    // that brings the addressed lane down to bit 0 grows as the offset shrinks.
    assign sh     = size_q == 2'b00 ? {~addr_q[1:0], 3'b000} : {~addr_q[1], 4'b0000};
    assign lane   = 16'(mem_rdata >> sh);
    assign ld_val = size_q == 2'b00 ? {{24{sext_q & lane[7]}}, lane[7:0]} :
                    size_q == 2'b01 ? {{16{sext_q & lane[15]}}, lane} : mem_rdata;
    assign mask   = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged = (mem_rdata & ~mask) | (({16'h0000, wdata_q} << sh) & mask);

    assign mem_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 16'h0;
            fault_q   <= 1'b0;
            rdata     <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                wr_q    <= wr;
                size_q  <= size;
                sext_q  <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata[15:0];
                fault_q <= bad;
                if (wr)
                    mem_wdata <= wdata;
            end
            // A sub-word store reuses READ to fetch the old word and merge into it.
            if (state == READ) begin
                if (wr_q)
                    mem_wdata <= merged;
                else
                    rdata <= ld_val;
            end
        end
    end

    // Enables decode straight from the state register so an asynchronous
    // reset drops them immediately.
    always_comb begin
        state_n   = state;
        busy      = state != IDLE;
        done      = state == DONE;
        fault     = state == DONE && fault_q;
        mem_read  = state == READ;
        mem_write = state == WRITE;
        case (state)
            IDLE:    if (req) state_n = bad ? DONE : (!wr || size != 2'b10) ? READ : WRITE;
            READ:    state_n = wr_q ? WRITE : DONE;
            WRITE:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural data memory.
module tb_mem_access_unit;
    logic        clk, reset, req, wr, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, done, fault, mem_write, mem_read;

    typedef struct {logic f; logic [31:0] rd; int lat; int nrd; int nwr;} exp_t;
    typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;

    exp_t        exp_q[$];
    wr_t         wq[$];
    logic [31:0] mem [0:255];
    logic [31:0] shadow [0:255];
    logic [31:0] exp_rdata;
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    int          checks = 0, failures = 0, lat = 0, nrd = 0, nwr = 0, ndone = 0;

    mem_access_unit #(.ADDR_LIMIT(1024)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .fault(fault), .rdata(rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (mem_write)
            mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input int off, input logic se);
        logic [7:0]  b [4];
        logic [15:0] h;
        b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
        h = {b[off & 2], b[(off & 2) + 1]};
        if (sz == 2'b00) return se ? {{24{b[off][7]}}, b[off]} : {24'h0, b[off]};
        if (sz == 2'b01) return se ? {{16{h[15]}}, h} : {16'h0, h};
        return w;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input int off, input logic [31:0] d);
        logic [7:0] b [4];
        b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
        if (sz == 2'b00) b[off] = d[7:0];
        else begin
            b[off & 2] = d[15:8];
            b[(off & 2) + 1] = d[7:0];
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[9:2]; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
        shadow[a[9:2]] = d;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; sign_ext = se; addr = a; wdata = d;
        @(posedge clk);
        lat = 0; nrd = 0; nwr = 0;
        #1 if (!hold) req = 1'b0;
    endtask

    // Builds the expectations for one access, pushes them, runs it and waits for done.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
        exp_t        e;
        wr_t         x;
        logic        b;
        logic [31:0] old;
        int          n0;
        b   = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0) || a >= 1024;
        old = shadow[a[9:2]];
        e.f = b;
        if (b) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!w) begin
            exp_rdata = ref_load(old, sz, int'(a[1:0]), se);
            e.lat = 2; e.nrd = 1; e.nwr = 0;
        end else begin
            x.a = {a[31:2], 2'b00};
            x.d = sz == 2'b10 ? d : ref_store(old, sz, int'(a[1:0]), d);
            wq.push_back(x);
            shadow[a[9:2]] = x.d;
            e.lat = sz == 2'b10 ? 2 : 3; e.nrd = sz == 2'b10 ? 0 : 1; e.nwr = 1;
        end
        e.rd = exp_rdata;
        exp_q.push_back(e);
        n0 = ndone;
        drive(w, sz, se, a, d, hold);
        for (int i = 0; i < 8 && ndone == n0; i++) @(posedge clk);
        if (ndone == n0) chk("done_timeout", 32'(ndone), 32'(n0 + 1));
        #1 req = 1'b0;
        chk("idle_after_done", 32'(busy), 32'h0);
    endtask

    initial begin
        exp_t e;
        wr_t  x;
        forever begin
            @(negedge clk);
            lat++;
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                if (wq.size() == 0) chk("unexpected_write", 32'h1, 32'h0);
                else begin
                    x = wq.pop_front();
                    chk("write_addr", mem_addr, x.a);
                    chk("write_data", mem_wdata, x.d);
                end
            end
            if (done) begin
                ndone++;
                if (exp_q.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
                else begin
                    e = exp_q.pop_front();
                    chk("fault", 32'(fault), 32'(e.f));
                    chk("rdata", rdata, e.rd);
                    chk("latency", 32'(lat), 32'(e.lat));
                    chk("read_cycles", 32'(nrd), 32'(e.nrd));
                    chk("write_cycles", 32'(nwr), 32'(e.nwr));
                end
            end
        end
    end

    initial begin
        logic seen;
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; pl_en = 1'b0; pl_idx = 8'h0; pl_data = 32'h0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
        #2;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        for (int i = 0; i < 256; i++) preload(32'(i * 4), 32'h0);
        @(negedge clk) reset = 1'b0;

        preload(32'h40, 32'h11223344);
        do_op(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 1'b0);
        preload(32'h40, 32'h80ff7f01);
        do_op(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 1'b0);
        do_op(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1'b0);
        do_op(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 1'b0);
        do_op(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1'b0);
        do_op(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 1'b0);
        do_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

        preload(32'h80, 32'haabbccdd);
        do_op(1'b1, 2'b00, 1'b0, 32'h83, 32'h55, 1'b0);
        do_op(1'b1, 2'b01, 1'b0, 32'h80, 32'hffff1234, 1'b0);
        do_op(1'b1, 2'b00, 1'b0, 32'h81, 32'h0000a5c3, 1'b0);
        do_op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0);

        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hdeadbeef, 1'b1);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        do_op(1'b0, 2'b10, 1'b0, 32'h3fc, 32'h0, 1'b0);

        do_op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
        do_op(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b0);
        do_op(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 1'b0);
        do_op(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
        do_op(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1'b0);
        do_op(1'b1, 2'b00, 1'b0, 32'hffff_fff0, 32'h77, 1'b0);

        x_abort();

        do_op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0);
        do_op(1'b1, 2'b00, 1'b0, 32'h82, 32'h66, 1'b0);
        do_op(1'b0, 2'b00, 1'b1, 32'h82, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size() + wq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Sub-word store interrupted by reset in its WRITE cycle: the write must
    // vanish before any clock edge and no done may follow.
    task automatic x_abort();
        wr_t  x;
        logic seen;
        x.a = 32'h80;
        x.d = ref_store(shadow[32], 2'b00, 1, 32'h99);
        wq.push_back(x);
        drive(1'b1, 2'b00, 1'b0, 32'h81, 32'h99, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            #1 seen = mem_write;
        end
        chk("abort_saw_write", 32'(seen), 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        exp_rdata = 32'h0;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        chk("abort_rdata", rdata, 32'h0);
    endtask
endmodule
